// File: rtl/rf_exec_ctrl.sv
// rf_exec_ctrl: 4-state sequencer (IDLE/READ/EXEC/WB) that runs one
// 16-bit instruction at a time against an external 8x8 register file.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   instr_valid, instr  - instruction offer (op/dst/src_a/src_b/imm)
//   instr_ready         - accept possible this cycle (IDLE, not in reset)
//   rf_ra, rf_rb        - read addresses, driven only in READ
//   rf_rd_a, rf_rd_b    - combinational read data
//   rf_we, rf_wa, rf_wd - write port, active only in WB of ops 1-8
//   done                - one-cycle retire pulse
//   zero, carry         - flags of the last written result
//   err                 - sticky illegal-opcode flag
//   busy                - instruction in flight
module rf_exec_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [2:0]  rf_ra,
    output logic [2:0]  rf_rb,
    input  logic [7:0]  rf_rd_a,
    input  logic [7:0]  rf_rd_b,
    output logic        rf_we,
    output logic [2:0]  rf_wa,
    output logic [7:0]  rf_wd,
    output logic        done,
    output logic        zero,
    output logic        carry,
    output logic        err,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_LDI = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;

    logic [1:0]  state;
    logic [15:0] ir;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [8:0]  result;
    logic [8:0]  alu;

    logic [3:0] ir_op;
    logic [2:0] ir_dst;
    logic [2:0] ir_sa;
    logic [2:0] ir_sb;
    logic [7:0] ir_imm;
    logic       ir_legal;
    logic       in_legal;

    assign ir_op  = ir[15:12];
    assign ir_dst = ir[11:9];
    assign ir_sa  = ir[8:6];
    assign ir_sb  = ir[5:3];
    assign ir_imm = ir[7:0];

    assign ir_legal = (ir_op != OP_NOP) && (ir_op <= OP_SHL);
    assign in_legal = (instr[15:12] != OP_NOP) &&
                      (instr[15:12] <= OP_SHL);

    // Outputs are gated by rst so an in-flight WB cannot write or
    // retire during the reset cycle.
    assign instr_ready = (state == IDLE) && !rst;
    assign busy        = (state != IDLE) && !rst;
    assign done        = (state == WB) && !rst;
    assign rf_we       = (state == WB) && ir_legal && !rst;

    assign rf_ra = (state == READ) ? ir_sa : 3'd0;
    assign rf_rb = (state == READ) ? ir_sb : 3'd0;
    assign rf_wa = rf_we ? ir_dst : 3'd0;
    assign rf_wd = rf_we ? result[7:0] : 8'd0;

    // Bit 8 of the ALU output is the carry/borrow flag candidate.
    always_comb begin
        alu = 9'd0;
        unique case (ir_op)
            OP_ADD:  alu = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB:  alu = {(op_a < op_b), op_a - op_b};
            OP_AND:  alu = {1'b0, op_a & op_b};
            OP_OR:   alu = {1'b0, op_a | op_b};
            OP_XOR:  alu = {1'b0, op_a ^ op_b};
            OP_MOV:  alu = {1'b0, op_a};
            OP_LDI:  alu = {1'b0, ir_imm};
            OP_SHL:  alu = {op_a[7], op_a[6:0], 1'b0};
            default: alu = 9'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ir     <= 16'd0;
            op_a   <= 8'd0;
            op_b   <= 8'd0;
            result <= 9'd0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= in_legal ? READ : WB;
                    end
                end
                READ: begin
                    op_a  <= rf_rd_a;
                    op_b  <= rf_rd_b;
                    state <= EXEC;
                end
                EXEC: begin
                    result <= alu;
                    state  <= WB;
                end
                WB: begin
                    if (ir_legal) begin
                        zero  <= (result[7:0] == 8'd0);
                        carry <= result[8];
                    end else if (ir_op != OP_NOP) begin
                        err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Directed bench for rf_exec_ctrl with a behavioural register file.
// Expected values are hand-computed from the instruction encodings.
module tb_rf_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'd0;
    logic        instr_ready;
    logic [2:0]  rf_ra, rf_rb, rf_wa;
    logic [7:0]  rf_rd_a, rf_rd_b, rf_wd;
    logic        rf_we, done, zero, carry, err, busy;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int done_cnt = 0;

    logic [7:0] rf_m [8];

    logic [2:0] o_ra, o_rb, o_wa;
    logic [7:0] o_wd;
    logic       o_we, o_done, o_z, o_c, o_busy, o_rdy, o_rdy2, o_err;

    always #5 clk = ~clk;

    rf_exec_ctrl dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready),
        .rf_ra(rf_ra), .rf_rb(rf_rb),
        .rf_rd_a(rf_rd_a), .rf_rd_b(rf_rd_b),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .done(done), .zero(zero), .carry(carry),
        .err(err), .busy(busy)
    );

    assign rf_rd_a = rf_m[rf_ra];
    assign rf_rd_b = rf_m[rf_rb];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_m[i] <= 8'd0;
        end else if (rf_we) begin
            rf_m[rf_wa] <= rf_wd;
        end
        if (rf_we) we_cnt <= we_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full ALU instruction: accept, READ, EXEC, WB, back to IDLE.
    task automatic go(input logic [15:0] w);
        instr = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr = 16'd0;
        o_ra = rf_ra; o_rb = rf_rb;
        o_busy = busy; o_rdy = instr_ready;
        tick();
        tick();
        o_we = rf_we; o_wa = rf_wa; o_wd = rf_wd; o_done = done;
        tick();
        o_z = zero; o_c = carry; o_rdy2 = instr_ready;
    endtask

    // NOP / illegal: accept goes straight to WB.
    task automatic go_short(input logic [15:0] w);
        instr = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr = 16'd0;
        o_we = rf_we; o_done = done;
        tick();
        o_err = err; o_rdy2 = instr_ready;
        o_z = zero; o_c = carry;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b1;
        instr = 16'h7655;
        tick();
        tick();
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", instr_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL rst_done_we got %b%b exp 00", done, rf_we); end
        instr_valid = 1'b0;
        instr = 16'd0;
        rst = 1'b0;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", instr_ready); end
        checks++; if ({zero, carry, err} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {zero, carry, err}); end
        checks++; if ({rf_ra, rf_rb, rf_wa, rf_wd} !== 17'd0) begin errors++; $display("FAIL rst_idle_addr got %h exp 0", {rf_ra, rf_rb, rf_wa, rf_wd}); end
        tick();
    endtask

    task automatic test_ldi();
        int we0, dn0;
        we0 = we_cnt;
        dn0 = done_cnt;
        go(16'h7655);
        checks++; if (o_ra !== 3'd1 || o_rb !== 3'd2) begin errors++; $display("FAIL ldi_raddr got %0d,%0d exp 1,2", o_ra, o_rb); end
        checks++; if (o_busy !== 1'b1 || o_rdy !== 1'b0) begin errors++; $display("FAIL ldi_busy got %b%b exp 10", o_busy, o_rdy); end
        checks++; if (o_we !== 1'b1 || o_wa !== 3'd3) begin errors++; $display("FAIL ldi_we_wa got %b,%0d exp 1,3", o_we, o_wa); end
        checks++; if (o_wd !== 8'h55) begin errors++; $display("FAIL ldi_wd got %h exp 55", o_wd); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL ldi_done got %b exp 1", o_done); end
        checks++; if (o_z !== 1'b0 || o_c !== 1'b0) begin errors++; $display("FAIL ldi_flags got %b%b exp 00", o_z, o_c); end
        checks++; if (done_cnt - dn0 !== 1 || we_cnt - we0 !== 1) begin errors++; $display("FAIL ldi_pulses got %0d,%0d exp 1,1", done_cnt - dn0, we_cnt - we0); end
        checks++; if (o_rdy2 !== 1'b1 || rf_m[3] !== 8'h55) begin errors++; $display("FAIL ldi_rf got %b,%h exp 1,55", o_rdy2, rf_m[3]); end
    endtask

    task automatic test_alu();
        go(16'h72F0);
        go(16'h7420);
        go(16'h1850);
        checks++; if (o_wa !== 3'd4 || o_wd !== 8'h10) begin errors++; $display("FAIL add got %0d,%h exp 4,10", o_wa, o_wd); end
        checks++; if (o_c !== 1'b1 || o_z !== 1'b0) begin errors++; $display("FAIL add_flags got c%b z%b exp c1 z0", o_c, o_z); end
        go(16'h2A88);
        checks++; if (o_wa !== 3'd5 || o_wd !== 8'h30) begin errors++; $display("FAIL sub got %0d,%h exp 5,30", o_wa, o_wd); end
        checks++; if (o_c !== 1'b1) begin errors++; $display("FAIL sub_carry got %b exp 1", o_c); end
        go(16'h5C48);
        checks++; if (o_wa !== 3'd6 || o_wd !== 8'h00) begin errors++; $display("FAIL xor got %0d,%h exp 6,00", o_wa, o_wd); end
        checks++; if (o_z !== 1'b1 || o_c !== 1'b0) begin errors++; $display("FAIL xor_flags got z%b c%b exp z1 c0", o_z, o_c); end
    endtask

    task automatic test_logic_hazard();
        go(16'h720C);
        go(16'h740A);
        go(16'h3650);
        checks++; if (o_wd !== 8'h08 || o_c !== 1'b0) begin errors++; $display("FAIL and got %h c%b exp 08 c0", o_wd, o_c); end
        go(16'h4650);
        checks++; if (o_wd !== 8'h0E || o_wa !== 3'd3) begin errors++; $display("FAIL or got %h,%0d exp 0e,3", o_wd, o_wa); end
        go(16'h2688);
        checks++; if (o_wd !== 8'hFE || o_c !== 1'b1) begin errors++; $display("FAIL sub_borrow got %h c%b exp fe c1", o_wd, o_c); end
        go(16'h1250);
        checks++; if (o_wa !== 3'd1 || o_wd !== 8'h16) begin errors++; $display("FAIL hazard got %0d,%h exp 1,16", o_wa, o_wd); end
        checks++; if (rf_m[1] !== 8'h16 || o_c !== 1'b0) begin errors++; $display("FAIL hazard_rf got %h c%b exp 16 c0", rf_m[1], o_c); end
    endtask

    task automatic test_shl_mov();
        go(16'h7281);
        go(16'h8E40);
        checks++; if (o_wa !== 3'd7 || o_wd !== 8'h02) begin errors++; $display("FAIL shl got %0d,%h exp 7,02", o_wa, o_wd); end
        checks++; if (o_c !== 1'b1 || o_z !== 1'b0) begin errors++; $display("FAIL shl_flags got c%b z%b exp c1 z0", o_c, o_z); end
        go(16'h61C0);
        checks++; if (o_wa !== 3'd0 || o_wd !== 8'h02) begin errors++; $display("FAIL mov got %0d,%h exp 0,02", o_wa, o_wd); end
        checks++; if (o_c !== 1'b0) begin errors++; $display("FAIL mov_carry got %b exp 0", o_c); end
    endtask

    task automatic test_nop_illegal();
        logic z0, c0;
        int we0;
        z0 = zero;
        c0 = carry;
        we0 = we_cnt;
        go_short(16'h0000);
        checks++; if (o_we !== 1'b0 || o_done !== 1'b1) begin errors++; $display("FAIL nop_wb got we%b done%b exp we0 done1", o_we, o_done); end
        checks++; if (o_err !== 1'b0 || o_rdy2 !== 1'b1) begin errors++; $display("FAIL nop_after got err%b rdy%b exp err0 rdy1", o_err, o_rdy2); end
        checks++; if (o_z !== z0 || o_c !== c0) begin errors++; $display("FAIL nop_flags got %b%b exp %b%b", o_z, o_c, z0, c0); end
        go_short(16'hA000);
        checks++; if (o_we !== 1'b0 || o_done !== 1'b1) begin errors++; $display("FAIL ill_wb got we%b done%b exp we0 done1", o_we, o_done); end
        checks++; if (o_err !== 1'b1 || o_rdy2 !== 1'b1) begin errors++; $display("FAIL ill_err got err%b rdy%b exp err1 rdy1", o_err, o_rdy2); end
        checks++; if (o_z !== z0 || o_c !== c0) begin errors++; $display("FAIL ill_flags got %b%b exp %b%b", o_z, o_c, z0, c0); end
        checks++; if (we_cnt !== we0) begin errors++; $display("FAIL nop_ill_writes got %0d exp %0d", we_cnt - we0, 0); end
        go(16'h1850);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog [3];
        int at [3];
        int k;
        logic acc;
        prog[0] = 16'h7211;
        prog[1] = 16'h7422;
        prog[2] = 16'h1650;
        k = 0;
        instr = prog[0];
        instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            checks++; if (busy && instr_ready) begin errors++; $display("FAIL b2b_ready_busy got 1 exp 0 cyc %0d", c); end
            acc = instr_ready && instr_valid;
            tick();
            if (acc) begin
                if (k < 3) at[k] = c;
                k++;
                if (k < 3) instr = prog[k];
                else begin
                    instr_valid = 1'b0;
                    instr = 16'd0;
                end
            end
        end
        checks++; if (k !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", k); end
        checks++; if (at[0] !== 0 || at[1] !== 4 || at[2] !== 8) begin errors++; $display("FAIL b2b_spacing got %0d,%0d,%0d exp 0,4,8", at[0], at[1], at[2]); end
        checks++; if (rf_m[3] !== 8'h33 || busy !== 1'b0) begin errors++; $display("FAIL b2b_result got %h busy%b exp 33 busy0", rf_m[3], busy); end
    endtask

    task automatic test_rst_abort();
        int we0, dn0;
        for (int pass = 0; pass < 2; pass++) begin
            we0 = we_cnt;
            dn0 = done_cnt;
            go(16'h7201);
            we0 = we_cnt;
            dn0 = done_cnt;
            instr = 16'h1850;
            instr_valid = 1'b1;
            tick();
            instr_valid = 1'b0;
            instr = 16'd0;
            tick();
            if (pass == 1) tick();
            rst = 1'b1;
            #1;
            checks++; if (rf_we !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort%0d_gate got we%b done%b exp 00", pass, rf_we, done); end
            checks++; if (busy !== 1'b0 || instr_ready !== 1'b0) begin errors++; $display("FAIL abort%0d_busy got %b%b exp 00", pass, busy, instr_ready); end
            @(posedge clk);
            #1;
            rst = 1'b0;
            #1;
            checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL abort%0d_ready got %b exp 1", pass, instr_ready); end
            checks++; if ({zero, carry, err} !== 3'b000) begin errors++; $display("FAIL abort%0d_flags got %b exp 000", pass, {zero, carry, err}); end
            tick();
            tick();
            tick();
            checks++; if (we_cnt !== we0 || done_cnt !== dn0) begin errors++; $display("FAIL abort%0d_pulses got %0d,%0d exp 0,0", pass, we_cnt - we0, done_cnt - dn0); end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu();
        test_logic_hazard();
        test_shl_mov();
        test_nop_illegal();
        test_back_to_back();
        test_rst_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
